// File: rtl/ssd_display_ctrl.sv
// N-digit multiplexed seven-segment controller: a serial double-dabble converter feeds a
// display register that is scanned one active-low anode at a time.
module ssd_display_ctrl #(
  parameter int NUM_DIGITS     = 4,
  parameter int NUM_WIDTH      = 13,
  parameter int REFRESH_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_WIDTH-1:0]  num_i,
  input  logic                  signed_i,
  input  logic                  blank_lz_i,
  output logic                  busy_o,
  output logic [NUM_DIGITS-1:0] anode_o,
  output logic [6:0]            seg_o
);

  function automatic int decDigits(input int w);
    longint unsigned v;
    int n;
    v = (64'd1 << w) - 64'd1;
    n = 1;
    while (v >= 64'd10) begin
      v = v / 64'd10;
      n++;
    end
    return n;
  endfunction

  function automatic longint unsigned pow10(input int n);
    longint unsigned v;
    v = 64'd1;
    for (int i = 0; i < n; i++) v = v * 64'd10;
    return v;
  endfunction

  function automatic logic [6:0] segCode(input logic [3:0] nib);
    case (nib)
      4'd0:    segCode = 7'b0000001;
      4'd1:    segCode = 7'b1001111;
      4'd2:    segCode = 7'b0010010;
      4'd3:    segCode = 7'b0000110;
      4'd4:    segCode = 7'b1001100;
      4'd5:    segCode = 7'b0100100;
      4'd6:    segCode = 7'b0100000;
      4'd7:    segCode = 7'b0001111;
      4'd8:    segCode = 7'b0000000;
      4'd9:    segCode = 7'b0000100;
      default: segCode = 7'b1111111;
    endcase
  endfunction

  localparam int DEC_N = decDigits(NUM_WIDTH);
  // The BCD register must hold every possible magnitude and every displayed digit.
  localparam int BCD_N = (DEC_N > NUM_DIGITS) ? DEC_N : NUM_DIGITS;
  localparam int BCD_W = 4 * BCD_N;
  localparam int CNT_W = $clog2(NUM_WIDTH + 1);
  localparam int REF_W = $clog2(REFRESH_CYCLES);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam longint unsigned POS_LIM = pow10(NUM_DIGITS) - 64'd1;
  localparam longint unsigned NEG_LIM = pow10(NUM_DIGITS - 1) - 64'd1;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t                    state, stateNext;
  logic [BCD_W-1:0]          bcd, bcdAdj;
  logic [NUM_WIDTH-1:0]      mag, magHold, magNow;
  logic [BCD_W+NUM_WIDTH-1:0] shiftCat;
  logic                      neg, negNow, blankLz;
  logic [CNT_W-1:0]          cnt;
  logic [63:0]               magWide;
  logic                      ovf;
  int                        msd, signPos;
  logic [6:0]                disp     [NUM_DIGITS];
  logic [6:0]                dispNext [NUM_DIGITS];
  logic [REF_W-1:0]          refCnt;
  logic [IDX_W-1:0]          digitIdx;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    stateNext = SHIFT;
      SHIFT:   if (cnt == CNT_W'(NUM_WIDTH - 1)) stateNext = COMMIT;
      COMMIT:  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  assign busy_o = (state != IDLE);

  assign negNow = signed_i & num_i[NUM_WIDTH-1];
  assign magNow = negNow ? (~num_i + NUM_WIDTH'(1)) : num_i;

  always_comb begin
    bcdAdj = bcd;
    for (int i = 0; i < BCD_N; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcdAdj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  assign shiftCat = {bcdAdj, mag} << 1;

  // Conversion datapath: sample in IDLE, one add-3/shift step per SHIFT cycle.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        neg     <= negNow;
        blankLz <= blank_lz_i;
        mag     <= magNow;
        magHold <= magNow;
        bcd     <= '0;
        cnt     <= '0;
      end
      SHIFT: begin
        bcd <= shiftCat[BCD_W+NUM_WIDTH-1:NUM_WIDTH];
        mag <= shiftCat[NUM_WIDTH-1:0];
        cnt <= cnt + CNT_W'(1);
      end
      default: ;
    endcase
  end

  assign magWide = 64'(magHold);
  assign ovf     = neg ? (magWide > NEG_LIM) : (magWide > POS_LIM);

  always_comb begin
    msd = 0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (bcd[4*k +: 4] != 4'd0) msd = k;
    end
    signPos = blankLz ? (msd + 1) : (NUM_DIGITS - 1);
    for (int k = 0; k < NUM_DIGITS; k++) begin
      dispNext[k] = segCode(bcd[4*k +: 4]);
      if (blankLz && (k > msd)) dispNext[k] = SEG_BLANK;
      if (neg && (k == signPos)) dispNext[k] = SEG_DASH;
      if (ovf) dispNext[k] = SEG_DASH;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_DIGITS; k++) disp[k] <= SEG_BLANK;
    end else if (state == COMMIT) begin
      for (int k = 0; k < NUM_DIGITS; k++) disp[k] <= dispNext[k];
    end
  end

  // Scan: each digit is lit for REFRESH_CYCLES clocks; outputs are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      refCnt   <= '0;
      digitIdx <= '0;
      anode_o  <= '1;
      seg_o    <= SEG_BLANK;
    end else begin
      if (refCnt == REF_W'(REFRESH_CYCLES - 1)) begin
        refCnt <= '0;
        if (digitIdx == IDX_W'(NUM_DIGITS - 1)) digitIdx <= '0;
        else                                    digitIdx <= digitIdx + IDX_W'(1);
      end else begin
        refCnt <= refCnt + REF_W'(1);
      end
      anode_o <= ~(NUM_DIGITS'(1) << digitIdx);
      seg_o   <= disp[digitIdx];
    end
  end

endmodule

// File: tb/tb_ssd_display_ctrl.sv
// Directed bench for ssd_display_ctrl with four digits, 13-bit input and a 4-cycle refresh.
module tb_ssd_display_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] num_i;
  logic        signed_i;
  logic        blank_lz_i;
  logic        busy_o;
  logic [3:0]  anode_o;
  logic [6:0]  seg_o;

  int total = 0;
  int bad   = 0;

  localparam logic [6:0] SEG [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                      7'b0000000, 7'b0000100};
  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] DS = 7'b1111110;

  ssd_display_ctrl #(.NUM_DIGITS(4), .NUM_WIDTH(13), .REFRESH_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .num_i(num_i), .signed_i(signed_i), .blank_lz_i(blank_lz_i),
    .busy_o(busy_o), .anode_o(anode_o), .seg_o(seg_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitFalls(input int n, input string tag);
    int   falls = 0;
    int   t = 0;
    logic prev;
    prev = busy_o;
    while (falls < n && t < 100) begin
      tick();
      t++;
      if (prev && !busy_o) falls++;
      prev = busy_o;
    end
    total++;
    assert (falls === n) else begin
      bad++;
      $error("FAIL %s busy falls got=%0d want=%0d", tag, falls, n);
    end
  endtask

  task automatic waitBusy(input logic level, input string tag);
    int t = 0;
    while (busy_o !== level && t < 60) begin
      tick();
      t++;
    end
    total++;
    assert (busy_o === level) else begin
      bad++;
      $error("FAIL %s busy wait got=%b want=%b", tag, busy_o, level);
    end
  endtask

  task automatic checkDigits(input logic [3:0][6:0] e, input string tag);
    logic [3:0] want;
    int t;
    for (int k = 0; k < 4; k++) begin
      want = ~(4'b0001 << k);
      t = 0;
      while (anode_o !== want && t < 24) begin
        tick();
        t++;
      end
      total++;
      assert (anode_o === want && seg_o === e[k]) else begin
        bad++;
        $error("FAIL %s digit%0d anode=%b seg=%b want anode=%b seg=%b",
               tag, k, anode_o, seg_o, want, e[k]);
      end
    end
  endtask

  task automatic setAndCheck(input logic [12:0] n, input logic s, input logic b,
                             input logic [3:0][6:0] e, input string tag);
    num_i      = n;
    signed_i   = s;
    blank_lz_i = b;
    waitFalls(2, tag);
    tick();
    checkDigits(e, tag);
  endtask

  initial begin
    int busyCnt;
    int errCnt;
    logic [3:0][6:0] w1234;
    logic [6:0] expSeg;

    rst = 1'b1;
    num_i = 13'd1234;
    signed_i = 1'b0;
    blank_lz_i = 1'b0;
    tick();
    tick();
    total++;
    assert (anode_o === 4'b1111) else begin bad++; $error("FAIL rst_anode got=%b want=1111", anode_o); end
    total++;
    assert (seg_o === BL) else begin bad++; $error("FAIL rst_seg got=%b want=%b", seg_o, BL); end
    total++;
    assert (busy_o === 1'b0) else begin bad++; $error("FAIL rst_busy got=%b want=0", busy_o); end

    rst = 1'b0;
    tick();
    total++;
    assert (anode_o === 4'b1110) else begin bad++; $error("FAIL first_anode got=%b want=1110", anode_o); end
    busyCnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy_o) busyCnt++;
      else if (busyCnt > 0) break;
      tick();
    end
    total++;
    assert (busyCnt === 14) else begin bad++; $error("FAIL busy_len got=%0d want=14", busyCnt); end

    setAndCheck(13'd1234, 1'b0, 1'b0, {SEG[1], SEG[2], SEG[3], SEG[4]}, "u1234");
    setAndCheck(13'd7,    1'b0, 1'b1, {BL, BL, BL, SEG[7]}, "u7_blz");
    setAndCheck(13'd0,    1'b0, 1'b1, {BL, BL, BL, SEG[0]}, "u0_blz");
    setAndCheck(13'd1030, 1'b0, 1'b1, {SEG[1], SEG[0], SEG[3], SEG[0]}, "u1030_blz");
    setAndCheck(13'h1FF9, 1'b1, 1'b1, {BL, BL, DS, SEG[7]}, "m7_blz");
    setAndCheck(13'h1FF9, 1'b1, 1'b0, {DS, SEG[0], SEG[0], SEG[7]}, "m7_full");
    setAndCheck(13'h1000, 1'b1, 1'b0, {DS, DS, DS, DS}, "m4096_ovf");
    setAndCheck(13'h1C19, 1'b1, 1'b1, {DS, SEG[9], SEG[9], SEG[9]}, "m999");
    setAndCheck(13'h1C18, 1'b1, 1'b1, {DS, DS, DS, DS}, "m1000_ovf");
    setAndCheck(13'd8191, 1'b0, 1'b0, {SEG[8], SEG[1], SEG[9], SEG[1]}, "u8191");
    setAndCheck(13'd1234, 1'b0, 1'b0, {SEG[1], SEG[2], SEG[3], SEG[4]}, "u1234_again");

    // Change the input mid-SHIFT: the pending commit must still show 1234.
    w1234 = {SEG[1], SEG[2], SEG[3], SEG[4]};
    waitBusy(1'b0, "mid_idle");
    waitBusy(1'b1, "mid_start");
    tick();
    tick();
    tick();
    num_i = 13'd5678;
    waitBusy(1'b0, "mid_commit");
    tick();
    errCnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      case (anode_o)
        4'b1110: expSeg = w1234[0];
        4'b1101: expSeg = w1234[1];
        4'b1011: expSeg = w1234[2];
        4'b0111: expSeg = w1234[3];
        default: expSeg = 7'bxxxxxxx;
      endcase
      if (seg_o !== expSeg) errCnt++;
    end
    total++;
    assert (errCnt === 0) else begin bad++; $error("FAIL mid_hold bad_cycles got=%0d want=0", errCnt); end
    waitFalls(1, "mid_next");
    tick();
    checkDigits({SEG[5], SEG[6], SEG[7], SEG[8]}, "u5678");

    // Reset during SHIFT and during an active scan.
    waitBusy(1'b0, "rst_idle");
    waitBusy(1'b1, "rst_start");
    tick();
    tick();
    rst = 1'b1;
    tick();
    total++;
    assert (anode_o === 4'b1111) else begin bad++; $error("FAIL mid_rst_anode got=%b want=1111", anode_o); end
    total++;
    assert (seg_o === BL) else begin bad++; $error("FAIL mid_rst_seg got=%b want=%b", seg_o, BL); end
    total++;
    assert (busy_o === 1'b0) else begin bad++; $error("FAIL mid_rst_busy got=%b want=0", busy_o); end
    rst = 1'b0;
    tick();
    total++;
    assert (anode_o === 4'b1110) else begin bad++; $error("FAIL post_rst_anode got=%b want=1110", anode_o); end
    errCnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (seg_o !== BL) errCnt++;
      tick();
    end
    total++;
    assert (errCnt === 0) else begin bad++; $error("FAIL post_rst_blank bad_cycles got=%0d want=0", errCnt); end
    waitFalls(1, "post_rst_commit");
    tick();
    checkDigits({SEG[5], SEG[6], SEG[7], SEG[8]}, "u5678_after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
